// File: rtl/route_sequencer_pkg.sv
// Shared definitions for the route sequencer: turn codes, FSM encoding and
// the packed layout of one stored route entry.
package route_sequencer_pkg;

  localparam int NODE_W  = 5;
  localparam int TURN_W  = 2;
  localparam int ENTRY_W = NODE_W + TURN_W;
  localparam int ADDR_W  = 5;

  localparam logic [1:0] TURN_STR   = 2'd0;
  localparam logic [1:0] TURN_RIGHT = 2'd1;
  localparam logic [1:0] TURN_BACK  = 2'd2;
  localparam logic [1:0] TURN_LEFT  = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOADED = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [TURN_W-1:0] turn;
  } route_entry_t;

endpackage

// File: rtl/route_sequencer_mem.sv
// Route storage: DEPTH x 7-bit register file, synchronous write and
// combinational read. Contents are deliberately left unreset.
module route_mem
  import route_sequencer_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic               clk_3125KHz,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_3125KHz) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/route_sequencer.sv
// Steps a pre-loaded node/turn route forward on each guard-timed node crossing
// and drives the line follower's turn_flag, realtime_pos and end_path inputs.
module route_sequencer
  import route_sequencer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int GUARD = 3125
) (
  input  logic              clk_3125KHz,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [NODE_W-1:0] load_node,
  input  logic [1:0]        load_turn,
  input  logic              load_last,
  input  logic              start,
  input  logic              clear,
  input  logic              node_changed,
  output logic [1:0]        turn_flag,
  output logic [NODE_W-1:0] realtime_pos,
  output logic              end_path,
  output logic              busy,
  output logic [5:0]        route_len
);

  localparam int GW = $clog2(GUARD + 1);
  localparam logic [5:0] DEPTH_L   = 6'(DEPTH);
  localparam logic [5:0] LAST_SLOT = 6'(DEPTH - 1);

  logic [1:0]         state, state_nxt;
  logic [5:0]         len_nxt;
  logic [ADDR_W-1:0]  idx, idx_nxt;
  logic [GW-1:0]      guard, guard_nxt;
  logic               mem_we;
  logic               node_acc;
  logic [5:0]         last_idx;
  logic [ENTRY_W-1:0] rd_word;
  route_entry_t       rd_entry;
  route_entry_t       wr_entry;

  assign load_ready = (state == ST_IDLE) && (route_len < DEPTH_L);
  assign node_acc   = node_changed && (guard == '0);
  assign last_idx   = route_len - 6'd1;
  assign rd_entry   = route_entry_t'(rd_word);
  assign wr_entry   = '{node: load_node, turn: load_turn};

  // The read port follows the next index so registered outputs show the
  // entry that becomes current on this edge.
  route_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_3125KHz (clk_3125KHz),
    .we          (mem_we),
    .waddr       (route_len[ADDR_W-1:0]),
    .wdata       (wr_entry),
    .raddr       (idx_nxt),
    .rdata       (rd_word)
  );

  always_comb begin
    state_nxt = state;
    len_nxt   = route_len;
    idx_nxt   = idx;
    guard_nxt = (guard != '0) ? guard - GW'(1) : guard;
    mem_we    = 1'b0;
    if (clear) begin
      state_nxt = ST_IDLE;
      len_nxt   = 6'd0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid && load_ready) begin
            mem_we  = 1'b1;
            len_nxt = route_len + 6'd1;
            if (load_last || (route_len == LAST_SLOT)) state_nxt = ST_LOADED;
          end
        end
        ST_LOADED, ST_DONE: begin
          if (start) begin
            state_nxt = ST_RUN;
            idx_nxt   = '0;
            guard_nxt = '0;
          end
        end
        ST_RUN: begin
          if (node_acc) begin
            guard_nxt = GW'(GUARD);
            if ({1'b0, idx} == last_idx) state_nxt = ST_DONE;
            else                         idx_nxt   = idx + ADDR_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      route_len    <= 6'd0;
      idx          <= '0;
      guard        <= '0;
      turn_flag    <= TURN_STR;
      realtime_pos <= '0;
      end_path     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state     <= state_nxt;
      route_len <= len_nxt;
      idx       <= idx_nxt;
      guard     <= guard_nxt;
      busy      <= (state_nxt == ST_RUN);
      end_path  <= (state_nxt == ST_DONE);
      turn_flag <= (state_nxt == ST_RUN) ? rd_entry.turn : TURN_STR;
      case (state_nxt)
        ST_RUN:  realtime_pos <= rd_entry.node;
        ST_DONE: realtime_pos <= realtime_pos;
        default: realtime_pos <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_route_sequencer.sv
// Scoreboard bench for route_sequencer: stimulus queues expected output
// snapshots tagged with a cycle number; a negedge monitor pops and compares.
module tb_route_sequencer;

  localparam int TG = 40;

  logic       clk_3125KHz = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [4:0] load_node = '0;
  logic [1:0] load_turn = '0;
  logic       load_last = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       node_changed = 1'b0;
  logic [1:0] turn_flag;
  logic [4:0] realtime_pos;
  logic       end_path;
  logic       busy;
  logic [5:0] route_len;

  route_sequencer #(.DEPTH(32), .GUARD(TG)) dut (
    .clk_3125KHz  (clk_3125KHz),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_node    (load_node),
    .load_turn    (load_turn),
    .load_last    (load_last),
    .start        (start),
    .clear        (clear),
    .node_changed (node_changed),
    .turn_flag    (turn_flag),
    .realtime_pos (realtime_pos),
    .end_path     (end_path),
    .busy         (busy),
    .route_len    (route_len)
  );

  always #5 clk_3125KHz = ~clk_3125KHz;

  typedef struct {
    int         cyc;
    string      nm;
    logic [1:0] tf;
    logic [4:0] rp;
    logic       ep;
    logic       bz;
    logic       lr;
    logic [5:0] len;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;

  always @(posedge clk_3125KHz) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_3125KHz);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [1:0] tf, input logic [4:0] rp,
                            input logic ep, input logic bz, input logic lr, input logic [5:0] len);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.tf = tf; e.rp = rp;
    e.ep = ep; e.bz = bz; e.lr = lr; e.len = len;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation whose cycle has been reached.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_3125KHz);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        ntests++;
        if (turn_flag !== e.tf || realtime_pos !== e.rp || end_path !== e.ep ||
            busy !== e.bz || load_ready !== e.lr || route_len !== e.len) begin
          nfail++;
          $display("FAIL %s: got tf=%0d pos=%0d end=%0b busy=%0b rdy=%0b len=%0d, want tf=%0d pos=%0d end=%0b busy=%0b rdy=%0b len=%0d",
                   e.nm, turn_flag, realtime_pos, end_path, busy, load_ready, route_len,
                   e.tf, e.rp, e.ep, e.bz, e.lr, e.len);
        end
      end
    end
  end

  task automatic load_one(input logic [4:0] n, input logic [1:0] t, input logic last);
    load_valid = 1'b1; load_node = n; load_turn = t; load_last = last;
    tick();
  endtask

  task automatic pulse_node();
    node_changed = 1'b1;
    tick();
    node_changed = 1'b0;
  endtask

  initial begin
    tick();
    expect_now("reset_state", 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd0);
    tick();
    rst = 1'b0;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    expect_now("start_ignored_idle", 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd0);

    // Three-entry route
    load_one(5'd4, 2'd0, 1'b0);
    expect_now("load1", 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd1);
    load_one(5'd9, 2'd1, 1'b0);
    expect_now("load2", 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd2);
    load_one(5'd12, 2'd3, 1'b1);
    expect_now("load3_loaded", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd3);
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    expect_now("load_ignored_loaded", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd3);

    start = 1'b1;
    tick();
    start = 1'b0;
    expect_now("run_entry0", 2'd0, 5'd4, 1'b0, 1'b1, 1'b0, 6'd3);

    pulse_node();
    expect_now("run_entry1", 2'd1, 5'd9, 1'b0, 1'b1, 1'b0, 6'd3);
    repeat (9) tick();
    pulse_node();
    expect_now("double_count_rejected", 2'd1, 5'd9, 1'b0, 1'b1, 1'b0, 6'd3);
    repeat (TG + 5) tick();
    pulse_node();
    expect_now("run_entry2", 2'd3, 5'd12, 1'b0, 1'b1, 1'b0, 6'd3);

    // Guard boundary: acceptance at t lets the next one in at t+GUARD+1 only.
    repeat (TG - 1) tick();
    node_changed = 1'b1;
    tick();
    expect_now("guard_edge_minus1", 2'd3, 5'd12, 1'b0, 1'b1, 1'b0, 6'd3);
    tick();
    node_changed = 1'b0;
    expect_now("done", 2'd0, 5'd12, 1'b1, 1'b0, 1'b0, 6'd3);
    repeat (2) tick();
    expect_now("done_holds", 2'd0, 5'd12, 1'b1, 1'b0, 1'b0, 6'd3);

    start = 1'b1;
    tick();
    start = 1'b0;
    expect_now("replay_entry0", 2'd0, 5'd4, 1'b0, 1'b1, 1'b0, 6'd3);
    pulse_node();
    expect_now("replay_guard_zeroed", 2'd1, 5'd9, 1'b0, 1'b1, 1'b0, 6'd3);

    repeat (TG + 2) tick();
    clear = 1'b1; node_changed = 1'b1;
    tick();
    clear = 1'b0; node_changed = 1'b0;
    expect_now("clear_beats_node", 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd0);

    // Full-depth route without load_last
    for (int i = 0; i < 32; i++) begin
      load_one(5'(31 - i), 2'(i % 4), 1'b0);
      expect_now($sformatf("fill%0d", i), 2'd0, 5'd0, 1'b0, 1'b0, (i < 31), 6'(i + 1));
    end
    tick();
    load_valid = 1'b0;
    expect_now("full_stays_loaded", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd32);

    start = 1'b1;
    tick();
    start = 1'b0;
    expect_now("full_entry0", 2'd0, 5'd31, 1'b0, 1'b1, 1'b0, 6'd32);
    pulse_node();
    expect_now("full_entry1", 2'd1, 5'd30, 1'b0, 1'b1, 1'b0, 6'd32);
    repeat (TG + 1) tick();
    pulse_node();
    expect_now("full_entry2", 2'd2, 5'd29, 1'b0, 1'b1, 1'b0, 6'd32);

    // Asynchronous reset between edges
    tick();
    #2;
    rst = 1'b1;
    expect_now("async_rst", 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd0);
    tick();
    rst = 1'b0;
    tick();
    expect_now("after_rst_idle", 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd0);

    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    if (q.size() > 0) begin
      ntests++;
      nfail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
